// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-ported data memory between the CPU
// (port 0) and a DMA/debug master (port 1). Optional port-1 bus lock: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic              last_gnt_q;
    logic              last_gnt_d;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;
    logic              lock_hold;
    logic              rd_acc;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} state_t;
    state_t state_q;

    assign lock_hold = (state_q == LOCK1) && lock1;

    // Lock FSM: enter on a locked port-1 accept, leave on the first cycle lock1 drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (gnt1 && lock1) state_q <= LOCK1;
                    else               state_q <= ARB;
                end
                LOCK1: begin
                    if (!lock1) state_q <= ARB;
                    else        state_q <= LOCK1;
                end
                default: state_q <= ARB;
            endcase
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock1;
    assign lock_hold   = 1'b0;
`endif

    // Grant selection: lock, then round-robin on contest, else the lone requester
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_hold) begin
            gnt1 = req1;
        end else if (req0 && req1) begin
            gnt0 = last_gnt_q;
            gnt1 = !last_gnt_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // Memory drive from the granted port; port 0 fields when idle
    always_comb begin
        if (gnt1) begin
            mem_addr = addr1;
            mem_data = wdata1;
            mem_rden = !we1;
            mem_wren = we1;
        end else begin
            mem_addr = addr0;
            mem_data = wdata0;
            mem_rden = gnt0 && !we0;
            mem_wren = gnt0 && we0;
        end
    end

    assign rd_acc     = mem_rden;
    assign last_gnt_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_gnt_q);

    // Read-tag pipeline: stage 0 takes the new read, later stages shift along
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = rd_acc;
        id_d[0]  = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    // State registers; reset drops any in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            vld_q      <= '0;
            id_q       <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] && !id_q[RD_LAT-1];
    assign rvalid1 = vld_q[RD_LAT-1] && id_q[RD_LAT-1];
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and a randomized run checked
// against a transaction-level model of dmem_arbiter (RD_LAT = 2).
module tb_dmem_arbiter;
    localparam int RD_LAT = 2;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req0, req1, we0, we1, lock1;
    logic [7:0]  addr0, addr1, mem_addr;
    logic [31:0] wdata0, wdata1, rdata0, rdata1, mem_data, mem_q;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_rden, mem_wren;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic [31:0] mq_pipe [RD_LAT];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic r, q0, q1, w0, w1;
        logic [7:0] a0, a1;
        logic [31:0] d0, d1;
        logic g0, g1, rd, wr;
        logic [7:0] ea;
        logic [31:0] ed;
        logic rv0, rv1;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t rq[$];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Single-ported memory with RD_LAT cycles of read latency
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mq_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) mq_pipe[i] <= mq_pipe[i-1];
    end
    assign mem_q = mq_pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic r, q0, q1, w0, w1, lk, input logic [7:0] a0, a1,
                         input logic [31:0] d0, d1);
        @(posedge clk);
        #1;
        rst = r; req0 = q0; req1 = q1; we0 = w0; we1 = w1; lock1 = lk;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
    endtask

    task automatic chk_bus(input string t, input logic g0, g1, rd, wr, input logic [7:0] ea,
                           input logic [31:0] ed, input logic rv0, rv1, input logic [31:0] erd);
        chk({t, " gnt0"}, {31'd0, gnt0}, {31'd0, g0});
        chk({t, " gnt1"}, {31'd0, gnt1}, {31'd0, g1});
        chk({t, " mem_rden"}, {31'd0, mem_rden}, {31'd0, rd});
        chk({t, " mem_wren"}, {31'd0, mem_wren}, {31'd0, wr});
        chk({t, " mem_addr"}, {24'd0, mem_addr}, {24'd0, ea});
        chk({t, " mem_data"}, mem_data, ed);
        chk({t, " rvalid0"}, {31'd0, rvalid0}, {31'd0, rv0});
        chk({t, " rvalid1"}, {31'd0, rvalid1}, {31'd0, rv1});
        if (rv0) chk({t, " rdata0"}, rdata0, erd);
        if (rv1) chk({t, " rdata1"}, rdata1, erd);
    endtask

    function automatic vec_t mk(input logic r, q0, q1, w0, w1, input logic [7:0] a0, a1,
                                input logic [31:0] d0, d1, input logic g0, g1, rd, wr,
                                input logic [7:0] ea, input logic [31:0] ed,
                                input logic rv0, rv1, input logic [31:0] erd);
        vec_t v;
        v.r = r; v.q0 = q0; v.q1 = q1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1; v.rd = rd; v.wr = wr; v.ea = ea;
        v.ed = ed; v.rv0 = rv0; v.rv1 = rv1; v.erd = erd;
        return v;
    endfunction

    logic        m_last, m_locked, was_locked, eg0, eg1, pend0, pend1, p, w, erv0, erv1;
    logic [7:0]  a;
    logic [31:0] d, erd;
    int          cyc;

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 32'h0; wdata1 = 32'h0;

        // reset with both requesting: nothing granted, port 0 fields on the bus
        vecs.push_back(mk(1,1,1,1,1, 8'h10,8'h11, 32'h11111111,32'h22222222, 0,0,0,0, 8'h10,32'h11111111, 0,0,32'h0));
        // write then read of 8'h10, data back RD_LAT cycles after the read grant
        vecs.push_back(mk(0,1,0,1,0, 8'h10,8'h00, 32'hDEADBEEF,32'h0, 1,0,0,1, 8'h10,32'hDEADBEEF, 0,0,32'h0));
        vecs.push_back(mk(0,1,0,0,0, 8'h10,8'h00, 32'h0,32'h0, 1,0,1,0, 8'h10,32'h0, 0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 1,0,32'hDEADBEEF));
        // contest for six cycles after reset alternates starting with port 0
        vecs.push_back(mk(1,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 0,0,32'h0));
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                vecs.push_back(mk(0,1,1,1,1, 8'h20,8'h21, 32'hA0A0A0A0,32'hB1B1B1B1, 1,0,0,1, 8'h20,32'hA0A0A0A0, 0,0,32'h0));
            else
                vecs.push_back(mk(0,1,1,1,1, 8'h20,8'h21, 32'hA0A0A0A0,32'hB1B1B1B1, 0,1,0,1, 8'h21,32'hB1B1B1B1, 0,0,32'h0));
        end
        // port 1 alone: three writes preload 1,2,3
        for (int i = 1; i <= 3; i++)
            vecs.push_back(mk(0,0,1,0,1, 8'h00,8'(i), 32'h0,32'(i), 0,1,0,1, 8'(i),32'(i), 0,0,32'h0));
        // back-to-back reads p0 @1, p1 @2, p0 @3 return in grant order
        vecs.push_back(mk(0,1,0,0,0, 8'h01,8'h00, 32'h0,32'h0, 1,0,1,0, 8'h01,32'h0, 0,0,32'h0));
        vecs.push_back(mk(0,0,1,0,0, 8'h09,8'h02, 32'h0,32'h0, 0,1,1,0, 8'h02,32'h0, 0,0,32'h0));
        vecs.push_back(mk(0,1,0,0,0, 8'h03,8'h00, 32'h0,32'h0, 1,0,1,0, 8'h03,32'h0, 1,0,32'h1));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 0,1,32'h2));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 1,0,32'h3));
        vecs.push_back(mk(0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0, 0,0,0,0, 8'h00,32'h0, 0,0,32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].q0, vecs[i].q1, vecs[i].w0, vecs[i].w1, 1'b0,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            chk_bus($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].rd, vecs[i].wr,
                    vecs[i].ea, vecs[i].ed, vecs[i].rv0, vecs[i].rv1, vecs[i].erd);
        end

        // read granted, then reset next cycle: the read never returns, port 0 wins next contest
        drive(0,1,0,0,0,0, 8'h01,8'h00, 32'h0,32'h0);
        chk_bus("rstdrop grant", 1,0,1,0, 8'h01,32'h0, 0,0,32'h0);
        drive(1,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0);
        chk_bus("rstdrop rst", 0,0,0,0, 8'h00,32'h0, 0,0,32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0);
            chk_bus($sformatf("rstdrop idle%0d", i), 0,0,0,0, 8'h00,32'h0, 0,0,32'h0);
        end
        drive(0,1,1,1,1,0, 8'h30,8'h31, 32'h5,32'h6);
        chk_bus("rstdrop contest", 1,0,0,1, 8'h30,32'h5, 0,0,32'h0);

`ifdef DMEM_ARB_LOCK_EN
        // locked port-1 write blocks port 0 until lock1 drops
        drive(0,0,1,0,1,1, 8'h00,8'h40, 32'h0,32'h7);
        chk_bus("lock take", 0,1,0,1, 8'h40,32'h7, 0,0,32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(0,1,0,1,0,1, 8'h41,8'h00, 32'h8,32'h0);
            chk_bus($sformatf("lock hold%0d", i), 0,0,0,0, 8'h41,32'h8, 0,0,32'h0);
        end
        drive(0,1,0,1,0,0, 8'h41,8'h00, 32'h8,32'h0);
        chk_bus("lock release", 1,0,0,1, 8'h41,32'h8, 0,0,32'h0);
`endif
        for (int i = 0; i < 3; i++) drive(0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0);
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];

        // randomized run against a transaction-level model
        m_last = 1'b1; m_locked = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        eg0 = 1'b0; eg1 = 1'b0; cyc = 0;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            if (it > 0) begin
                if (rst) begin
                    m_last = 1'b1; m_locked = 1'b0; rq.delete();
                end else begin
                    if (eg0 || eg1) begin
                        p = eg1;
                        a = p ? addr1 : addr0;
                        w = p ? we1 : we0;
                        d = p ? wdata1 : wdata0;
                        if (w) shadow[a] = d;
                        else rq.push_back('{cyc + RD_LAT, p, shadow[a]});
                        m_last = p;
                    end
                    was_locked = m_locked;
                    if (!was_locked) m_locked = LOCK_EN && eg1 && lock1;
                    else             m_locked = lock1;
                    if (eg0) pend0 = 1'b0;
                    if (eg1) pend1 = 1'b0;
                end
                cyc++;
            end
            #1;
            rst = (it == 0) || ($urandom_range(0, 59) == 0);
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom_range(0, 7)); wdata0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom_range(0, 7)); wdata1 = $urandom;
            end
            req0 = pend0; req1 = pend1; lock1 = 1'($urandom_range(0, 1));
            @(negedge clk);

            eg0 = 1'b0; eg1 = 1'b0;
            if (!rst) begin
                if (LOCK_EN && m_locked && lock1) eg1 = req1;
                else if (req0 && req1) begin
                    if (m_last) eg0 = 1'b1;
                    else        eg1 = 1'b1;
                end else begin
                    eg0 = req0; eg1 = req1;
                end
            end
            erv0 = 1'b0; erv1 = 1'b0; erd = 32'h0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv0 = !rq[0].port; erv1 = rq[0].port; erd = rq[0].data;
                void'(rq.pop_front());
            end
            chk_bus($sformatf("rand%0d", it), eg0, eg1,
                    (eg0 && !we0) || (eg1 && !we1), (eg0 && we0) || (eg1 && we1),
                    eg1 ? addr1 : addr0, eg1 ? wdata1 : wdata0, erv0, erv1, erd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
